memory_controller: RTL and testbench
====================================

# memory_controller

Byte-serial arbiter and sequencer for the single shared RAM port. It accepts word fetches from the instruction cache and load/store requests from the load & store buffer, and grants one at a time. It splits each request into byte accesses on the 8-bit RAM bus and reassembles or extends the returned data. It sits between the two requesters and the memory, and it honours the pipeline flush on misprediction.

## Interface
Parameters:
- LSB_OP_WIDTH, 3, width of the load/store op code

Ports:
- clockIn  in  1  system clock, all logic on rising edge
- resetIn  in  1  synchronous reset, active-low
- flush  in  1  misprediction flush; aborts speculative reads
- memIn  in  8  RAM read data (valid the cycle after the address edge)
- memOut  out  8  RAM write data
- memAddr  out  32  RAM byte address
- memWrite  out  1  RAM write enable
- icacheValid  in  1  fetch request, held until icacheReady
- icacheAddr  in  32  fetch address
- icacheReady  out  1  one-cycle completion pulse
- icacheData  out  32  fetched word, valid with icacheReady
- lsbValid  in  1  LSB request, held until lsbReady
- lsbReadWrite  in  1  1 = load, 0 = store
- lsbAddr  in  32  byte address
- lsbOp  in  LSB_OP_WIDTH  size/extension code
- lsbData  in  32  store data
- lsbReady  out  1  one-cycle completion pulse
- lsbResult  out  32  extended load result, valid with lsbReady

## Operation
- States:
  - IDLE
  - READ
  - WRITE
  - DONE
- Reset (resetIn low at an edge):
  - State goes to IDLE and lastGrant goes to ICACHE.
  - All outputs go to 0: memAddr, memOut, memWrite, icacheReady, icacheData, lsbReady, lsbResult.
  - Reset overrides everything, including a store in progress.
- Arbitration in IDLE:
  - If flush is high, nothing is accepted that cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not lastGrant wins. lastGrant is updated on every grant.
  - After reset, the LSB therefore wins the first contention.
- Byte count n:
  - Fetch: 4.
  - LSB by lsbOp:
    - 000 (LB), 011 (LBU): 1
    - 001 (LH), 100 (LHU): 2
    - 010 (LW) and reserved 101–111: 4
  - Stores use the same codes: 000 = SB, 001 = SH, otherwise SW.
- Bytes are little-endian at consecutive addresses. No alignment is required.
- Read:
  - Byte k is addressed at edge E_k and captured from memIn at edge E_{k+1} into result bits [8k+7:8k].
- Load extension:
  - LB/LH sign-extend from bit 7 or bit 15.
  - LBU/LHU zero-extend.
  - Fetches return the raw word.
- Write:
  - At edge E_k, memAddr = A+k, memOut = byte k of lsbData, memWrite = 1.
  - memWrite is 0 in every non-WRITE cycle.
- DONE:
  - Lasts exactly one cycle and lets the requester drop valid before re-arbitration.
  - The ready pulse coincides with DONE.
- Flush during READ:
  - At the next edge, go to IDLE. No ready pulse; result outputs unchanged.
- Flush during WRITE:
  - Ignored. Stores are committed and always complete.
- memAddr and memOut hold their last values when idle.

## Timing
- Accept edge E0 (request sampled in IDLE): memAddr ← A, state ← READ/WRITE; for a write, memOut/memWrite ← byte 0 / 1.
- Edges E1..E_{n-1}: memAddr ← A+k. For a write, memOut ← byte k; for a read, byte k−1 is captured.
- Edge E_n:
  - Read: last byte captured and result registered.
  - Write: memWrite ← 0.
  - Both: ready ← 1, state ← DONE.
- Latency: ready is high in the cycle after E_n, i.e. n cycles after acceptance.
  - Word: 4 cycles.
  - Half: 2 cycles.
  - Byte: 1 cycle.
- Edge E_{n+1}: ready ← 0, state ← IDLE.
- Earliest next accept is E_{n+2}. Back-to-back word transactions therefore take 6 cycles each.
- A flush sampled at edge E_k of a read means no further captures and no pulse; a new request can be accepted at E_{k+1}.

## Test plan
- Fetch, 0x100 holding bytes 78 56 34 12:
  - memAddr steps 0x100..0x103 and memWrite stays 0.
  - icacheReady pulses 4 cycles after accept with icacheData 0x12345678.
- Loads:
  - Byte 0x80 at 0x20: LB → lsbResult 0xFFFFFF80; LBU → 0x00000080.
  - Bytes 01 80 at 0x30: LH → 0xFFFF8001; LHU → 0x00008001.
  - Each lsbReady arrives at the latency for its size.
- SW 0xDEADBEEF at 0x200:
  - memWrite is high for exactly 4 cycles with memOut EF, BE, AD, DE at addresses 0x200..0x203.
  - A following LW at 0x200 returns 0xDEADBEEF.
- Contention:
  - Both valid in the first cycle after reset: LSB is granted first, then the fetch.
  - With both held continuously, grants alternate LSB, ICACHE, LSB.
  - No accept occurs during DONE.
- Flush:
  - Flush at E2 of a fetch: no icacheReady, state returns to IDLE, next request accepted at E3.
  - Flush during SW: all 4 bytes are written and lsbReady still pulses.
- Reset mid-store: resetIn low after E1 of SW → next cycle memWrite 0, all outputs 0, state IDLE, and only byte 0 is written.

Source files
------------

// File: rtl/memory_controller.sv
// memory_controller: arbitrates the instruction cache and the load/store buffer
// onto the single 8-bit RAM port, splitting each request into little-endian
// byte accesses and reassembling/extending the returned data.
module memory_controller #(
    parameter int unsigned LSB_OP_WIDTH = 3
) (
    input  logic                    clockIn,
    input  logic                    resetIn,
    input  logic                    flush,
    input  logic [7:0]              memIn,
    output logic [7:0]              memOut,
    output logic [31:0]             memAddr,
    output logic                    memWrite,
    input  logic                    icacheValid,
    input  logic [31:0]             icacheAddr,
    output logic                    icacheReady,
    output logic [31:0]             icacheData,
    input  logic                    lsbValid,
    input  logic                    lsbReadWrite,
    input  logic [31:0]             lsbAddr,
    input  logic [LSB_OP_WIDTH-1:0] lsbOp,
    input  logic [31:0]             lsbData,
    output logic                    lsbReady,
    output logic [31:0]             lsbResult
);

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned BYTE_WIDTH  = 8;
    localparam int unsigned COUNT_WIDTH = 3;

    localparam logic [LSB_OP_WIDTH-1:0] OP_B  = LSB_OP_WIDTH'(0);
    localparam logic [LSB_OP_WIDTH-1:0] OP_H  = LSB_OP_WIDTH'(1);
    localparam logic [LSB_OP_WIDTH-1:0] OP_BU = LSB_OP_WIDTH'(3);
    localparam logic [LSB_OP_WIDTH-1:0] OP_HU = LSB_OP_WIDTH'(4);

    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_LSB    = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } stateT;

    // Number of bytes moved for a given load/store code; reserved codes act as words.
    function automatic logic [COUNT_WIDTH-1:0] opBytes(input logic [LSB_OP_WIDTH-1:0] op);
        if (op == OP_B || op == OP_BU) begin
            return COUNT_WIDTH'(1);
        end else if (op == OP_H || op == OP_HU) begin
            return COUNT_WIDTH'(2);
        end
        return COUNT_WIDTH'(4);
    endfunction

    // Sign or zero extension of the assembled load bytes.
    function automatic logic [DATA_WIDTH-1:0] extendLoad(input logic [LSB_OP_WIDTH-1:0] op,
                                                         input logic [DATA_WIDTH-1:0] w);
        if (op == OP_B) begin
            return {{24{w[7]}}, w[7:0]};
        end else if (op == OP_BU) begin
            return {24'h0, w[7:0]};
        end else if (op == OP_H) begin
            return {{16{w[15]}}, w[15:0]};
        end else if (op == OP_HU) begin
            return {16'h0, w[15:0]};
        end
        return w;
    endfunction

    stateT                    state, stateNext;
    logic                     lastGrant, lastGrantNext;
    logic                     ownerLsb, ownerLsbNext;
    logic [LSB_OP_WIDTH-1:0]  opReg, opNext;
    logic [ADDR_WIDTH-1:0]    baseAddr, baseAddrNext;
    logic [DATA_WIDTH-1:0]    storeData, storeDataNext;
    logic [COUNT_WIDTH-1:0]   byteCount, byteCountNext;
    logic [COUNT_WIDTH-1:0]   issued, issuedNext;
    logic [DATA_WIDTH-1:0]    rdBuf, rdBufNext;
    logic [ADDR_WIDTH-1:0]    memAddrNext;
    logic [BYTE_WIDTH-1:0]    memOutNext;
    logic                     memWriteNext;
    logic                     icacheReadyNext;
    logic [DATA_WIDTH-1:0]    icacheDataNext;
    logic                     lsbReadyNext;
    logic [DATA_WIDTH-1:0]    lsbResultNext;

    logic                     grantLsb;
    logic                     grantIcache;
    logic                     moreBytes;
    logic [1:0]               capIdx;

    // Round-robin grant decision, only meaningful while idle and not flushing.
    assign grantLsb    = (state == IDLE) && !flush && lsbValid &&
                         (!icacheValid || (lastGrant == GRANT_ICACHE));
    assign grantIcache = (state == IDLE) && !flush && icacheValid &&
                         (!lsbValid || (lastGrant == GRANT_LSB));
    assign moreBytes   = issued < byteCount;
    assign capIdx      = 2'(issued - COUNT_WIDTH'(1));

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            state       <= IDLE;
            lastGrant   <= GRANT_ICACHE;
            ownerLsb    <= 1'b0;
            opReg       <= '0;
            baseAddr    <= '0;
            storeData   <= '0;
            byteCount   <= '0;
            issued      <= '0;
            rdBuf       <= '0;
            memAddr     <= '0;
            memOut      <= '0;
            memWrite    <= 1'b0;
            icacheReady <= 1'b0;
            icacheData  <= '0;
            lsbReady    <= 1'b0;
            lsbResult   <= '0;
        end else begin
            state       <= stateNext;
            lastGrant   <= lastGrantNext;
            ownerLsb    <= ownerLsbNext;
            opReg       <= opNext;
            baseAddr    <= baseAddrNext;
            storeData   <= storeDataNext;
            byteCount   <= byteCountNext;
            issued      <= issuedNext;
            rdBuf       <= rdBufNext;
            memAddr     <= memAddrNext;
            memOut      <= memOutNext;
            memWrite    <= memWriteNext;
            icacheReady <= icacheReadyNext;
            icacheData  <= icacheDataNext;
            lsbReady    <= lsbReadyNext;
            lsbResult   <= lsbResultNext;
        end
    end

    // Next-state logic: grant, byte sequencing, flush abort of reads, one DONE cycle.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (grantLsb) begin
                    stateNext = lsbReadWrite ? READ : WRITE;
                end else if (grantIcache) begin
                    stateNext = READ;
                end
            end
            READ: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (!moreBytes) begin
                    stateNext = DONE;
                end
            end
            WRITE: begin
                if (!moreBytes) begin
                    stateNext = DONE;
                end
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Next values of the registered outputs and transaction context.
    always_comb begin
        lastGrantNext   = lastGrant;
        ownerLsbNext    = ownerLsb;
        opNext          = opReg;
        baseAddrNext    = baseAddr;
        storeDataNext   = storeData;
        byteCountNext   = byteCount;
        issuedNext      = issued;
        rdBufNext       = rdBuf;
        memAddrNext     = memAddr;
        memOutNext      = memOut;
        memWriteNext    = 1'b0;
        icacheReadyNext = 1'b0;
        icacheDataNext  = icacheData;
        lsbReadyNext    = 1'b0;
        lsbResultNext   = lsbResult;
        unique case (state)
            IDLE: begin
                if (grantLsb) begin
                    lastGrantNext = GRANT_LSB;
                    ownerLsbNext  = 1'b1;
                    opNext        = lsbOp;
                    baseAddrNext  = lsbAddr;
                    storeDataNext = lsbData;
                    byteCountNext = opBytes(lsbOp);
                    issuedNext    = COUNT_WIDTH'(1);
                    rdBufNext     = '0;
                    memAddrNext   = lsbAddr;
                    if (!lsbReadWrite) begin
                        memOutNext   = lsbData[7:0];
                        memWriteNext = 1'b1;
                    end
                end else if (grantIcache) begin
                    lastGrantNext = GRANT_ICACHE;
                    ownerLsbNext  = 1'b0;
                    baseAddrNext  = icacheAddr;
                    byteCountNext = COUNT_WIDTH'(4);
                    issuedNext    = COUNT_WIDTH'(1);
                    rdBufNext     = '0;
                    memAddrNext   = icacheAddr;
                end
            end
            READ: begin
                if (!flush) begin
                    rdBufNext[{capIdx, 3'b000} +: BYTE_WIDTH] = memIn;
                    if (moreBytes) begin
                        memAddrNext = baseAddr + ADDR_WIDTH'(issued);
                        issuedNext  = issued + COUNT_WIDTH'(1);
                    end else if (ownerLsb) begin
                        lsbResultNext = extendLoad(opReg, rdBufNext);
                        lsbReadyNext  = 1'b1;
                    end else begin
                        icacheDataNext  = rdBufNext;
                        icacheReadyNext = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (moreBytes) begin
                    memAddrNext  = baseAddr + ADDR_WIDTH'(issued);
                    memOutNext   = storeData[{issued[1:0], 3'b000} +: BYTE_WIDTH];
                    memWriteNext = 1'b1;
                    issuedNext   = issued + COUNT_WIDTH'(1);
                end else begin
                    lsbReadyNext = 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: randomized and directed checks of memory_controller
// against a byte-array memory model kept in the bench.
module tb_memory_controller;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  memIn;
    logic [7:0]  memOut;
    logic [31:0] memAddr;
    logic        memWrite;
    logic        icacheValid = 1'b0;
    logic [31:0] icacheAddr = '0;
    logic        icacheReady;
    logic [31:0] icacheData;
    logic        lsbValid = 1'b0;
    logic        lsbReadWrite = 1'b0;
    logic [31:0] lsbAddr = '0;
    logic [2:0]  lsbOp = '0;
    logic [31:0] lsbData = '0;
    logic        lsbReady;
    logic [31:0] lsbResult;

    memory_controller #(.LSB_OP_WIDTH(3)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .flush(flush),
        .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .memWrite(memWrite),
        .icacheValid(icacheValid), .icacheAddr(icacheAddr),
        .icacheReady(icacheReady), .icacheData(icacheData),
        .lsbValid(lsbValid), .lsbReadWrite(lsbReadWrite), .lsbAddr(lsbAddr),
        .lsbOp(lsbOp), .lsbData(lsbData), .lsbReady(lsbReady), .lsbResult(lsbResult)
    );

    always #5 clockIn = ~clockIn;

    // RAM seen by the DUT, and the bench's independent view of memory contents.
    logic [7:0]  ram   [0:1023];
    logic [7:0]  model [0:1023];
    logic [31:0] wAddr [$];
    logic [7:0]  wData [$];
    int          checks = 0;
    int          errors = 0;
    int          icPulses = 0;
    logic [31:0] lastFetch = '0;

    assign memIn = ram[memAddr[9:0]];

    always @(posedge clockIn) begin
        if (memWrite) begin
            ram[memAddr[9:0]] = memOut;
            wAddr.push_back(memAddr);
            wData.push_back(memOut);
        end
    end

    always @(negedge clockIn) begin
        if (icacheReady) icPulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nBytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++) w = w + (32'(model[10'(a + 32'(k))]) << (8 * k));
        return w;
    endfunction

    // Expected load value from plain arithmetic on the model bytes.
    function automatic logic [31:0] expLoad(input logic [31:0] a, input logic [2:0] op);
        int v;
        v = int'(modelWord(a, nBytes(op)));
        if (op == 3'd0 && v >= 128)   v = v - 256;
        if (op == 3'd1 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a[9:0]]   = b;
        model[a[9:0]] = b;
    endtask

    task automatic runLsb(input logic rw, input logic [31:0] a, input logic [2:0] op,
                          input logic [31:0] d, input bit flushMid);
        int n, cyc, wr;
        logic [31:0] expd;
        n = nBytes(op);
        expd = rw ? expLoad(a, op) : 32'h0;
        wAddr.delete();
        wData.delete();
        lsbValid = 1'b1; lsbReadWrite = rw; lsbAddr = a; lsbOp = op; lsbData = d;
        cyc = 0; wr = 0;
        while (lsbReady !== 1'b1 && cyc < 16) begin
            @(negedge clockIn);
            cyc++;
            if (flushMid) flush = 1'b1;
            if (memWrite) wr++;
        end
        flush = 1'b0;
        lsbValid = 1'b0;
        check("lsbLatency", 32'(cyc), 32'(n + 1));
        if (rw) begin
            check("lsbResult", lsbResult, expd);
            check("loadNoWrite", 32'(wr), 32'h0);
        end else begin
            check("storeWriteCycles", 32'(wr), 32'(n));
            check("storeLogSize", 32'(wAddr.size()), 32'(n));
            for (int k = 0; k < n && k < wAddr.size(); k++) begin
                check("storeAddr", wAddr[k], a + 32'(k));
                check("storeByte", 32'(wData[k]), (d >> (8 * k)) & 32'hFF);
            end
            for (int k = 0; k < n; k++) model[10'(a + 32'(k))] = 8'((d >> (8 * k)) & 32'hFF);
        end
        @(negedge clockIn);
        check("lsbPulse", 32'(lsbReady), 32'h0);
    endtask

    task automatic runFetch(input logic [31:0] a);
        int cyc, wr;
        logic [31:0] expd;
        expd = modelWord(a, 4);
        icacheValid = 1'b1; icacheAddr = a;
        cyc = 0; wr = 0;
        while (icacheReady !== 1'b1 && cyc < 16) begin
            @(negedge clockIn);
            cyc++;
            if (memWrite) wr++;
            if (cyc <= 4) check("fetchAddr", memAddr, a + 32'(cyc - 1));
        end
        icacheValid = 1'b0;
        check("fetchLatency", 32'(cyc), 32'd5);
        check("fetchData", icacheData, expd);
        check("fetchNoWrite", 32'(wr), 32'h0);
        lastFetch = expd;
        @(negedge clockIn);
        check("fetchPulse", 32'(icacheReady), 32'h0);
    endtask

    initial begin
        int ord [$];
        int tim [$];
        int pulsesBefore;
        logic [31:0] expLw;

        for (int i = 0; i < 1024; i++) begin
            model[i] = 8'($urandom);
            ram[i]   = model[i];
        end
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        poke(32'h20, 8'h80);
        poke(32'h30, 8'h01); poke(32'h31, 8'h80);

        // Reset values.
        repeat (3) @(negedge clockIn);
        check("rstMemAddr", memAddr, 32'h0);
        check("rstMemOut", 32'(memOut), 32'h0);
        check("rstMemWrite", 32'(memWrite), 32'h0);
        check("rstIcReady", 32'(icacheReady), 32'h0);
        check("rstIcData", icacheData, 32'h0);
        check("rstLsbReady", 32'(lsbReady), 32'h0);
        check("rstLsbResult", lsbResult, 32'h0);

        // Contention from the first cycle after reset: LSB, ICACHE, LSB, ...
        expLw = modelWord(32'h40, 4);
        resetIn = 1'b1;
        icacheValid = 1'b1; icacheAddr = 32'h100;
        lsbValid = 1'b1; lsbReadWrite = 1'b1; lsbAddr = 32'h40; lsbOp = 3'd2;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clockIn);
            if (lsbReady) begin
                ord.push_back(1); tim.push_back(c);
                check("contLsbData", lsbResult, expLw);
            end
            if (icacheReady) begin
                ord.push_back(0); tim.push_back(c);
                check("contIcData", icacheData, 32'h12345678);
            end
        end
        icacheValid = 1'b0; lsbValid = 1'b0;
        check("contCount", 32'(ord.size()), 32'd5);
        if (ord.size() >= 3) begin
            check("contFirstLsb", 32'(ord[0]), 32'd1);
            check("contSecondIc", 32'(ord[1]), 32'd0);
            check("contThirdLsb", 32'(ord[2]), 32'd1);
            check("contFirstTime", 32'(tim[0]), 32'd5);
            for (int i = 0; i + 1 < tim.size(); i++)
                check("contSpacing", 32'(tim[i + 1] - tim[i]), 32'd6);
        end
        repeat (2) @(negedge clockIn);

        // Directed fetch and loads.
        runFetch(32'h100);
        check("fetchWord", lastFetch, 32'h12345678);
        runLsb(1'b1, 32'h20, 3'd0, 32'h0, 1'b0);
        check("lbValue", lsbResult, 32'hFFFFFF80);
        runLsb(1'b1, 32'h20, 3'd3, 32'h0, 1'b0);
        check("lbuValue", lsbResult, 32'h00000080);
        runLsb(1'b1, 32'h30, 3'd1, 32'h0, 1'b0);
        check("lhValue", lsbResult, 32'hFFFF8001);
        runLsb(1'b1, 32'h30, 3'd4, 32'h0, 1'b0);
        check("lhuValue", lsbResult, 32'h00008001);

        // Store word then read it back.
        runLsb(1'b0, 32'h200, 3'd2, 32'hDEADBEEF, 1'b0);
        runLsb(1'b1, 32'h200, 3'd2, 32'h0, 1'b0);
        check("swLwValue", lsbResult, 32'hDEADBEEF);

        // Flush sampled at E2 of a fetch; a load is accepted at E3.
        pulsesBefore = icPulses;
        icacheValid = 1'b1; icacheAddr = 32'h104;
        @(negedge clockIn);
        @(negedge clockIn);
        flush = 1'b1; icacheValid = 1'b0;
        @(negedge clockIn);
        flush = 1'b0;
        runLsb(1'b1, 32'h20, 3'd3, 32'h0, 1'b0);
        check("flushNoIcReady", 32'(icPulses - pulsesBefore), 32'h0);
        check("flushIcDataKept", icacheData, lastFetch);

        // Flush during a store is ignored.
        runLsb(1'b0, 32'h210, 3'd2, $urandom, 1'b1);
        runLsb(1'b1, 32'h210, 3'd2, 32'h0, 1'b0);

        // Randomized mix of fetches, loads and stores.
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = 32'($urandom_range(0, 1016));
            if (kind == 0) runFetch(a);
            else runLsb(kind == 1, a, 3'($urandom_range(0, 7)), $urandom, 1'b0);
        end

        // Reset sampled at E1 of a word store: only byte 0 reaches memory.
        wAddr.delete(); wData.delete();
        lsbValid = 1'b1; lsbReadWrite = 1'b0; lsbAddr = 32'h300; lsbOp = 3'd2; lsbData = 32'hCAFEF00D;
        @(negedge clockIn);
        check("midStoreWrite", 32'(memWrite), 32'h1);
        resetIn = 1'b0;
        @(negedge clockIn);
        check("rstStoreMemWrite", 32'(memWrite), 32'h0);
        check("rstStoreMemAddr", memAddr, 32'h0);
        check("rstStoreMemOut", 32'(memOut), 32'h0);
        check("rstStoreLsbResult", lsbResult, 32'h0);
        check("rstStoreIcData", icacheData, 32'h0);
        check("rstStoreLog", 32'(wAddr.size()), 32'd1);
        if (wAddr.size() >= 1) check("rstStoreByte0", 32'(wData[0]), 32'h0D);
        model[10'h300] = 8'h0D;
        lsbValid = 1'b0;
        resetIn = 1'b1;
        @(negedge clockIn);
        repeat (3) @(negedge clockIn);
        check("rstStoreNoMore", 32'(wAddr.size()), 32'd1);
        runLsb(1'b1, 32'h300, 3'd2, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
